// File: rtl/threshold_controller.sv
// Threshold controller: debounced up/down keys with auto-repeat adjust an
// 8-bit pending threshold; threshold and enable commit on frame start only.
module threshold_controller #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_RATE     = 5000000,
  parameter int unsigned STEP            = 4,
  parameter int unsigned INIT_THRESHOLD  = 128
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic       iKEY_UP,
  input  logic       iKEY_DN,
  input  logic       iSW_EN,
  input  logic       iFrameStart,
  output logic [7:0] oThreshold,
  output logic       oEnable,
  output logic       oUpdate,
  output logic [7:0] oPending
);

  localparam int unsigned MAX_A   = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
  localparam int unsigned MAX_CNT = (MAX_A > REPEAT_RATE) ? MAX_A : REPEAT_RATE;
  localparam int          CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RR_LAST  = CNT_W'(REPEAT_RATE - 1);
  localparam logic [8:0]       STEP9    = 9'(STEP);
  localparam logic [7:0]       INIT_THR = 8'(INIT_THRESHOLD);

  typedef enum logic [2:0] {
    S_IDLE, S_DEBOUNCE, S_HOLD, S_REPEAT, S_RELEASE
  } state_t;

  typedef enum logic [1:0] {
    K_NONE, K_UP, K_DN
  } key_t;

  logic up_meta_q, up_sync_q;
  logic dn_meta_q, dn_sync_q;
  logic sw_meta_q, sw_sync_q;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dir_up_q, dir_up_d;
  logic [7:0]       pending_q, pending_d;
  logic [7:0]       thr_q, thr_d;
  logic             en_q, en_d;
  logic             upd_q, upd_d;

  key_t key;
  key_t dir_key;
  logic step;
  logic [8:0] sum9, diff9;

  // Two-flop synchronisers; reset to the released levels
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      up_meta_q <= 1'b1;
      up_sync_q <= 1'b1;
      dn_meta_q <= 1'b1;
      dn_sync_q <= 1'b1;
      sw_meta_q <= 1'b0;
      sw_sync_q <= 1'b0;
    end else begin
      up_meta_q <= iKEY_UP;
      up_sync_q <= up_meta_q;
      dn_meta_q <= iKEY_DN;
      dn_sync_q <= dn_meta_q;
      sw_meta_q <= iSW_EN;
      sw_sync_q <= sw_meta_q;
    end
  end

  // Key decode: exactly one key pressed gives a direction, otherwise none
  always_comb begin
    key = K_NONE;
    if (!up_sync_q && dn_sync_q)      key = K_UP;
    else if (up_sync_q && !dn_sync_q) key = K_DN;
    dir_key = dir_up_q ? K_UP : K_DN;
  end

  // Key FSM next state: debounce, first step, hold delay, repeat, release
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dir_up_d = dir_up_q;
    step     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (key != K_NONE) begin
          dir_up_d = (key == K_UP);
          state_d  = S_DEBOUNCE;
          cnt_d    = '0;
        end
      end
      S_DEBOUNCE: begin
        if (key != dir_key) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          step    = 1'b1;
          state_d = S_HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_HOLD: begin
        if (key != dir_key) begin
          state_d = S_RELEASE;
          cnt_d   = '0;
        end else if (cnt_q == RD_LAST) begin
          step    = 1'b1;
          state_d = S_REPEAT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_REPEAT: begin
        if (key != dir_key) begin
          state_d = S_RELEASE;
          cnt_d   = '0;
        end else if (cnt_q == RR_LAST) begin
          step  = 1'b1;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RELEASE: begin
        if (key != K_NONE) begin
          cnt_d = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Saturating 9-bit step of the pending threshold
  always_comb begin
    sum9      = {1'b0, pending_q} + STEP9;
    diff9     = {1'b0, pending_q} - STEP9;
    pending_d = pending_q;
    if (step) begin
      if (dir_up_q) pending_d = sum9[8]  ? 8'hFF : sum9[7:0];
      else          pending_d = diff9[8] ? 8'h00 : diff9[7:0];
    end
  end

  // Frame-boundary commit; samples pending before any same-cycle step
  always_comb begin
    thr_d = thr_q;
    en_d  = en_q;
    upd_d = 1'b0;
    if (iFrameStart) begin
      thr_d = pending_q;
      en_d  = sw_sync_q;
      upd_d = (pending_q != thr_q) || (sw_sync_q != en_q);
    end
  end

  // State, pending and committed output registers
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      dir_up_q  <= 1'b0;
      pending_q <= INIT_THR;
      thr_q     <= INIT_THR;
      en_q      <= 1'b0;
      upd_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dir_up_q  <= dir_up_d;
      pending_q <= pending_d;
      thr_q     <= thr_d;
      en_q      <= en_d;
      upd_q     <= upd_d;
    end
  end

  assign oThreshold = thr_q;
  assign oEnable    = en_q;
  assign oUpdate    = upd_q;
  assign oPending   = pending_q;

endmodule

// File: tb/tb_threshold_controller.sv
// Bench for threshold_controller: commit table, scoreboard of pending-value
// changes predicted from key timing, and hand sequences for corner cases.
module tb_threshold_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_up = 1'b1;
  logic       key_dn = 1'b1;
  logic       sw_en = 1'b0;
  logic       frame = 1'b0;
  logic [7:0] thr, pend;
  logic       en, upd;

  always #5 clk = ~clk;

  threshold_controller #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (16),
    .REPEAT_RATE    (4),
    .STEP           (8),
    .INIT_THRESHOLD (128)
  ) dut (
    .iCLK       (clk),
    .iRST_N     (rst_n),
    .iKEY_UP    (key_up),
    .iKEY_DN    (key_dn),
    .iSW_EN     (sw_en),
    .iFrameStart(frame),
    .oThreshold (thr),
    .oEnable    (en),
    .oUpdate    (upd),
    .oPending   (pend)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int model_pend = 128;
  int model_thr = 128;
  logic [7:0] last_pend = 8'd128;

  typedef struct {
    int cyc;
    int val;
  } ev_t;
  ev_t sb[$];

  typedef struct {
    logic sw;
    logic fs;
    int   thr;
    logic en;
    logic upd;
  } vec_t;
  vec_t tbl[9];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Every observed change of oPending must match the next predicted event
  always @(posedge clk) begin
    ev_t e;
    #2;
    if (!rst_n) begin
      last_pend = pend;
    end else if (pend !== last_pend) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sb_unexpected: got %0d expected %0d (cycle %0d)", pend, last_pend, cyc);
      end else begin
        e = sb.pop_front();
        check("sb_cycle", cyc, e.cyc);
        check("sb_value", int'(pend), e.val);
      end
      last_pend = pend;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int stepv(input int v, input bit up);
    if (up) return (v + 8 > 255) ? 255 : v + 8;
    return (v < 8) ? 0 : v - 8;
  endfunction

  // Key seen by the FSM on edges c0+3 .. c0+last_off; steps at +7, +16, then every +4
  task automatic push_press(input bit up, input int c0, input int last_off);
    int t;
    int gap;
    int nv;
    t = c0 + 7;
    gap = 16;
    while (t <= c0 + last_off) begin
      nv = stepv(model_pend, up);
      if (nv != model_pend) sb.push_back('{t, nv});
      model_pend = nv;
      t += gap;
      gap = 4;
    end
  endtask

  task automatic press(input bit up, input int len);
    push_press(up, cyc, len + 2);
    if (up) key_up = 1'b0;
    else    key_dn = 1'b0;
    repeat (len) tick();
    key_up = 1'b1;
    key_dn = 1'b1;
    repeat (14) tick();
  endtask

  task automatic frame_pulse(input string name, input int exp_upd);
    frame = 1'b1;
    tick();
    frame = 1'b0;
    model_thr = model_pend;
    check({name, "_thr"}, int'(thr), model_thr);
    check({name, "_upd"}, int'(upd), exp_upd);
    tick();
    check({name, "_upd_off"}, int'(upd), 0);
  endtask

  initial begin
    tbl[0] = '{1'b1, 1'b0, 128, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 128, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 1'b1, 128, 1'b1, 1'b1};
    tbl[3] = '{1'b1, 1'b0, 128, 1'b1, 1'b0};
    tbl[4] = '{1'b1, 1'b1, 128, 1'b1, 1'b0};
    tbl[5] = '{1'b0, 1'b0, 128, 1'b1, 1'b0};
    tbl[6] = '{1'b0, 1'b0, 128, 1'b1, 1'b0};
    tbl[7] = '{1'b0, 1'b1, 128, 1'b0, 1'b1};
    tbl[8] = '{1'b0, 1'b0, 128, 1'b0, 1'b0};

    // Reset values
    repeat (3) tick();
    check("rst_thr", int'(thr), 128);
    check("rst_pend", int'(pend), 128);
    check("rst_en", int'(en), 0);
    check("rst_upd", int'(upd), 0);
    rst_n = 1'b1;
    repeat (2) tick();
    frame_pulse("frame_nochange", 0);

    // Enable switch commit table
    for (int i = 0; i < 9; i++) begin
      sw_en = tbl[i].sw;
      frame = tbl[i].fs;
      tick();
      check($sformatf("tbl%0d_thr", i), int'(thr), tbl[i].thr);
      check($sformatf("tbl%0d_en", i), int'(en), int'(tbl[i].en));
      check($sformatf("tbl%0d_upd", i), int'(upd), int'(tbl[i].upd));
    end
    frame = 1'b0;

    // Single up press, committed on the next frame
    press(1'b1, 10);
    check("up_pend", int'(pend), 136);
    check("up_thr_hold", int'(thr), 128);
    frame_pulse("up_commit", 1);
    check("up_sb_empty", sb.size(), 0);

    // Held down key from 128 with auto-repeat
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    model_pend = 128;
    model_thr = 128;
    check("rst2_thr", int'(thr), 128);
    tick();
    press(1'b0, 40);
    check("hold_pend", int'(pend), 80);
    check("hold_sb_empty", sb.size(), 0);

    // Glitch and conflict: no steps
    press(1'b1, 3);
    key_up = 1'b0;
    key_dn = 1'b0;
    repeat (20) tick();
    key_up = 1'b1;
    key_dn = 1'b1;
    repeat (14) tick();
    check("noop_pend", int'(pend), 80);

    // Step on the same edge as frame start commits the old value
    frame_pulse("pre_commit", 1);
    push_press(1'b1, cyc, 12);
    key_up = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      frame = (i == 7);
      tick();
      if (i == 7) begin
        check("coinc_thr", int'(thr), 80);
        check("coinc_upd", int'(upd), 0);
        check("coinc_pend", int'(pend), 88);
      end
    end
    frame = 1'b0;
    key_up = 1'b1;
    repeat (14) tick();
    frame_pulse("coinc_next", 1);
    check("coinc_next_val", int'(thr), 88);

    // Saturation at both ends
    while (model_pend < 248) press(1'b1, 6);
    check("sat_248", int'(pend), 248);
    for (int i = 0; i < 4; i++) begin
      press(1'b1, 6);
      check($sformatf("sat_hi%0d", i), int'(pend), 255);
    end
    while (model_pend > 7) press(1'b0, 6);
    check("sat_7", int'(pend), 7);
    press(1'b0, 6);
    check("sat_lo0", int'(pend), 0);
    press(1'b0, 6);
    check("sat_lo1", int'(pend), 0);
    check("sat_sb_empty", sb.size(), 0);

    // Reset while auto-repeating
    sw_en = 1'b1;
    repeat (3) tick();
    frame_pulse("pre_rst", 1);
    check("pre_rst_en", int'(en), 1);
    push_press(1'b1, cyc, 30);
    key_up = 1'b0;
    repeat (30) tick();
    #3;
    rst_n = 1'b0;
    #1;
    check("mid_rst_thr", int'(thr), 128);
    check("mid_rst_pend", int'(pend), 128);
    check("mid_rst_en", int'(en), 0);
    check("mid_rst_upd", int'(upd), 0);
    model_pend = 128;
    model_thr = 128;
    key_up = 1'b1;
    sw_en = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    check("post_rst_pend", int'(pend), 128);
    check("final_sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/threshold_controller.md
# threshold_controller

Run-time controller for the live binarisation stage of the camera-to-LCD path. It turns two push-buttons and a slide switch into an 8-bit threshold and an enable for the gray-level thresholder. Keys are synchronised and debounced, and holding a key auto-repeats. Outputs change only on a frame boundary, so the LCD never shows a frame with a mid-frame threshold change.

## Interface
- DEBOUNCE_CYCLES, 50000: cycles a key level must be stable before it is accepted (1 ms at 50 MHz).
- REPEAT_DELAY, 25000000: cycles a key must be held after its first step before auto-repeat starts.
- REPEAT_RATE, 5000000: cycles between auto-repeat steps.
- STEP, 4: threshold increment/decrement per step (1..255).
- INIT_THRESHOLD, 128: threshold after reset.

- iCLK  in  1  system clock.
- iRST_N  in  1  asynchronous, active-low reset.
- iKEY_UP  in  1  raw key, active-low (pressed = 0), asynchronous to iCLK.
- iKEY_DN  in  1  raw key, active-low, asynchronous to iCLK.
- iSW_EN  in  1  raw enable switch, active-high, asynchronous.
- iFrameStart  in  1  one-cycle pulse at start of frame (vsync), synchronous to iCLK.
- oThreshold  out  8  committed threshold to the thresholder.
- oEnable  out  1  committed thresholder enable.
- oUpdate  out  1  one-cycle pulse: committed outputs changed.
- oPending  out  8  uncommitted threshold, for on-screen/7-seg display.

## Operation
- Synchronisers: iKEY_UP, iKEY_DN and iSW_EN each pass through a 2-flop synchroniser. All downstream logic uses the synchronised levels.
- Key decode: up = synced iKEY_UP low and synced iKEY_DN high. dn = the reverse. Both pressed or neither pressed = none.
- Key FSM states:
  - IDLE: on up or dn, latch the direction and go to DEBOUNCE. Clear the counter.
  - DEBOUNCE: count cycles while the same decode persists. Any other decode returns to IDLE. When the count reaches DEBOUNCE_CYCLES-1, issue one step and go to HOLD.
  - HOLD: count to REPEAT_DELAY-1, then issue a step and go to REPEAT. A decode other than the latched direction goes to RELEASE.
  - REPEAT: issue a step every REPEAT_RATE cycles. A decode other than the latched direction goes to RELEASE.
  - RELEASE: require decode = none for DEBOUNCE_CYCLES consecutive cycles, then go to IDLE. Any press restarts the count.
- Step arithmetic: done at 9-bit width and saturated.
  - up: pending = min(pending + STEP, 255).
  - dn: pending = max(pending - STEP, 0).
  - No wrap-around.
- Commit: on the cycle iFrameStart = 1, register oThreshold <= pending and oEnable <= synced iSW_EN.
  - If either value differs from its previous committed value, oUpdate = 1 on the following cycle only.
- Simultaneous step and iFrameStart in one cycle: the commit takes the pre-step pending value. The step lands in pending and is committed at the next frame.
- iFrameStart with no change: outputs are re-registered unchanged and no oUpdate is issued.
- iFrameStart is ignored in no state. Commit is independent of the key FSM.

## Timing
- Reset values (asserted asynchronously, released synchronously to iCLK):
  - oThreshold = INIT_THRESHOLD, oPending = INIT_THRESHOLD.
  - oEnable = 0, oUpdate = 0.
  - FSM = IDLE, all counters 0, synchroniser flops = released levels (keys 1, switch 0).
- Key press to oPending change: 2 (sync) + DEBOUNCE_CYCLES + 1 cycles.
- iFrameStart high in cycle N: oThreshold/oEnable valid in cycle N+1, oUpdate high in cycle N+1 only.
- Held key: first step at debounce end. Second step REPEAT_DELAY cycles later. Subsequent steps every REPEAT_RATE cycles.
- Reset mid-operation (any state, mid-count): all state returns to reset values immediately. Pending steps and the committed threshold are lost.
- A key glitch shorter than DEBOUNCE_CYCLES produces no step.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, REPEAT_DELAY=16, REPEAT_RATE=4, STEP=8, INIT_THRESHOLD=128.

- Reset, then iFrameStart pulse:
  - During reset: oThreshold=128, oEnable=0, oUpdate=0.
  - After the pulse: no oUpdate.
- Press iKEY_UP for 10 cycles, release, then pulse iFrameStart:
  - oPending=136 exactly 7 cycles after the press.
  - oThreshold stays 128 until the pulse, then 136, with one oUpdate pulse.
- Hold iKEY_DN for 40 cycles from pending 128:
  - Steps at debounce end, +16, +20, +24… cycles.
  - oPending goes 120, 112, 104, …; the step count matches the hold length exactly.
- Saturation: from 248, four up presses give 255, 255, 255, 255. From 4, one dn press gives 0. No wrap observed on oPending.
- Glitch and conflict cases, each with no step:
  - iKEY_UP low for 3 cycles.
  - Both keys pressed 20 cycles.
  - Switch iSW_EN 0→1 with iFrameStart: oEnable=1, oUpdate pulses once.
- Step coinciding with iFrameStart:
  - oThreshold takes the old pending value. The new value commits on the next iFrameStart.
  - Assert iRST_N=0 during REPEAT: all outputs return to reset values in the same cycle.
